// File: rtl/reg_acc.sv
// Register accumulator: load/clear/inc/dec in one cycle, bit-serial shifts via a down-counter.
// Define REG_ACC_ROTATE_EN to make shifts rotate instead of filling with zeros.
module reg_acc #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] bus,
    input  logic [SHW-1:0]   shamt,
    input  logic             out_en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bus_out,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | ready to accept an op
    // SHIFT | shifting one bit per edge until the counter reaches 0
    typedef enum logic {IDLE, SHIFT} state_e;

`ifdef REG_ACC_ROTATE_EN
    localparam bit ROTATE = 1'b1;
`else
    localparam bit ROTATE = 1'b0;
`endif

    localparam logic [SHW-1:0] SH_MAX = SHW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        left_d  = left_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    done_d = 1'b1;
                    case (op)
                        3'b001: begin
                            acc_d   = bus;
                            carry_d = 1'b0;
                        end
                        3'b010: begin
                            acc_d   = '0;
                            carry_d = 1'b0;
                        end
                        3'b011: {carry_d, acc_d} = {1'b0, acc_q} + {{WIDTH{1'b0}}, 1'b1};
                        // Borrow appears as the extra top bit going to 1 on 0 - 1.
                        3'b100: {carry_d, acc_d} = {1'b0, acc_q} - {{WIDTH{1'b0}}, 1'b1};
                        3'b101, 3'b110: begin
                            left_d = (op == 3'b101);
                            if (shamt == '0) begin
                                carry_d = 1'b0;
                            end else begin
                                done_d  = 1'b0;
                                cnt_d   = (shamt > SH_MAX) ? SH_MAX : shamt;
                                state_d = SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                if (left_q) begin
                    carry_d = acc_q[WIDTH-1];
                    acc_d   = {acc_q[WIDTH-2:0], ROTATE & acc_q[WIDTH-1]};
                end else begin
                    carry_d = acc_q[0];
                    acc_d   = {ROTATE & acc_q[0], acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out     = acc_q;
    assign bus_out = out_en ? acc_q : '0;
    assign zero    = (acc_q == '0);
    assign carry   = carry_q;
    assign busy    = (state_q == SHIFT);
    assign done    = done_q;

endmodule

// File: doc/reg_acc.md
REG_ACC -- requirements
Module: reg_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning accumulator and bus data width (WIDTH >= 2).
REQ-002 SHALL have derived parameter SHW = $clog2(WIDTH)+1, the shift-amount width, so that a shift of WIDTH is encodable.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port op_valid  input  1  operation strobe, sampled on the rising edge.
REQ-006 SHALL have port op  input  3  operation code.
REQ-007 SHALL have port bus  input  WIDTH  load data.
REQ-008 SHALL have port shamt  input  SHW  shift amount for shift ops.
REQ-009 SHALL have port out_en  input  1  bus output enable.
REQ-010 SHALL have port out  output  WIDTH  accumulator value, always visible.
REQ-011 SHALL have port bus_out  output  WIDTH  equal to out when out_en=1, else all-zero (combinational).
REQ-012 SHALL have port zero  output  1  combinational, 1 when out==0.
REQ-013 SHALL have port carry  output  1  registered carry/borrow/shift-out flag.
REQ-014 SHALL have port busy  output  1  multi-cycle shift in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL accept an op only at a rising edge with op_valid=1 and busy=0; op_valid while busy=1 is ignored, with no queuing.
REQ-017 SHALL decode op: 000 hold, 001 load bus, 010 clear, 011 increment, 100 decrement, 101 shift left, 110 shift right, 111 hold.
REQ-018 SHALL, for ops 000/001/010/011/100/111, write the result at the accepting edge and drive done=1 for exactly the following cycle.
REQ-019 SHALL keep carry unchanged on hold ops, and clear it to 0 on load and clear.
REQ-020 SHALL, on increment, wrap modulo 2^WIDTH; carry=1 only when all-ones wraps to 0, else carry=0.
REQ-021 SHALL, on decrement, wrap modulo 2^WIDTH; carry=1 (borrow) only when 0 wraps to all-ones, else carry=0.
REQ-022 SHALL run a state machine with states IDLE and SHIFT; accepting a shift with shamt>0 loads a counter with min(shamt,WIDTH), sets busy=1 and enters SHIFT; the accepting edge does not shift.
REQ-023 SHALL, in SHIFT, shift out by one bit per rising edge, set carry to the bit shifted out, and decrement the counter.
REQ-024 SHALL, at the edge where the counter reaches 0, return to IDLE, clear busy and raise done for one cycle; total latency is n+1 edges for shift amount n.
REQ-025 SHALL clamp shamt>WIDTH to WIDTH; a shift of WIDTH without rotate yields 0, with carry holding the last bit shifted out.
REQ-026 SHALL treat a shift with shamt=0 as a single-cycle op: value unchanged, carry=0, no busy, done next cycle.
REQ-027 SHALL hold op, bus and shamt don't-care while busy; only the values captured at acceptance apply.

Reset
REQ-028 SHALL, while rst=0, asynchronously force out=0, carry=0, busy=0, done=0, counter=0 and state IDLE; zero therefore reads 1.
REQ-029 SHALL abort an in-progress shift on reset, with no done pulse; the first op can be accepted at the first rising edge after rst returns to 1.

Configuration
REQ-030 SHALL, when REG_ACC_ROTATE_EN is defined, rotate on shifts: the bit leaving one end re-enters the other end, and carry still captures it.
REQ-031 SHALL, when REG_ACC_ROTATE_EN is undefined, shift zeros in at the vacated end; all other behaviour is identical.

Verification
REQ-032 SHALL cover: reset, then load 64 with WIDTH=8 -> out=64, done pulse next cycle; then out_en=0 -> bus_out=0; out_en=1 -> bus_out=64.
REQ-033 SHALL cover: load 255, then increment -> out=0, carry=1, zero=1; then decrement -> out=255, carry=1; then decrement -> out=254, carry=0.
REQ-034 SHALL cover: load 8'b1001_0110, shift left with shamt=3 -> busy for 3 cycles, done pulses once; without rotate out=8'b1011_0000, carry=0; with REG_ACC_ROTATE_EN out=8'b1011_0100, carry=0.
REQ-035 SHALL cover: during busy, op_valid with load 55 -> ignored; shift result unchanged, no extra done.
REQ-036 SHALL cover: shift right with shamt=12 on 8'hFF without rotate -> clamped to 8, out=0, carry=1; shamt=0 -> out unchanged, no busy, done next cycle.
REQ-037 SHALL cover: rst driven low mid-shift -> out=0, busy=0, no done pulse; after release, load 94 -> out=94.
